// File: rtl/exu_sprw_simd.sv
// Packed 4x8-bit signed SIMD execute unit: three-stage pipeline (E1 issue, E2 lane ops/products, E3 reduction).
// Build option: define RV_SPRW_SATADD_EN to turn f3=111 into saturating SATADD8; otherwise it decodes as ADD8.
module exu_sprw_simd #(
    parameter logic [6:0] OPC = 7'b0001011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        in_valid,
    input  logic [31:0] instr,
    input  logic [31:0] ra,
    input  logic [31:0] rb,
    output logic        out_valid,
    output logic [31:0] out,
    output logic [31:0] acc
);

    localparam logic [2:0] F3_ADD8   = 3'b000;
    localparam logic [2:0] F3_SUB8   = 3'b001;
    localparam logic [2:0] F3_MAX8   = 3'b010;
    localparam logic [2:0] F3_MIN8   = 3'b011;
    localparam logic [2:0] F3_DOT8   = 3'b100;
    localparam logic [2:0] F3_DOTACC = 3'b101;
    localparam logic [2:0] F3_ACCCLR = 3'b110;
    localparam logic [2:0] F3_SAT8   = 3'b111;

    // Per-lane element op; DOT/ACC ops ignore the lane result, so any value is fine for them.
    function automatic logic [7:0] lane_op(input logic [2:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
        logic [7:0] r;
`ifdef RV_SPRW_SATADD_EN
        logic [8:0] s9;
`endif
        r = a + b;
        case (op)
            F3_SUB8: r = a - b;
            F3_MAX8: r = ($signed(a) > $signed(b)) ? a : b;
            F3_MIN8: r = ($signed(a) < $signed(b)) ? a : b;
`ifdef RV_SPRW_SATADD_EN
            F3_SAT8: begin
                s9 = {a[7], a} + {b[7], b};
                if (s9[8] != s9[7]) r = s9[8] ? 8'h80 : 8'h7F;
                else                r = s9[7:0];
            end
`endif
            default: r = a + b;
        endcase
        return r;
    endfunction

    logic        accept;
    logic        unused_instr;

    logic        v2_q;
    logic [2:0]  f3_2_q;
    logic [31:0] ra_q;
    logic [31:0] rb_q;

    logic [31:0]      lane_d;
    logic [3:0][15:0] prod_d;

    logic             v3_q;
    logic [2:0]       f3_3_q;
    logic [31:0]      lane_q;
    logic [3:0][15:0] prod_q;

    logic [31:0] dot_e3;
    logic [31:0] out_d;
    logic [31:0] acc_d;
    logic        out_valid_q;
    logic [31:0] out_q;
    logic [31:0] acc_q;

    assign accept       = in_valid & (instr[6:0] == OPC) & ~freeze;
    assign unused_instr = ^{instr[31:15], instr[11:7]};

    // E1 -> E2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q   <= 1'b0;
            f3_2_q <= 3'b000;
            ra_q   <= 32'h0;
            rb_q   <= 32'h0;
        end else if (!freeze) begin
            v2_q <= accept;
            if (accept) begin
                f3_2_q <= instr[14:12];
                ra_q   <= ra;
                rb_q   <= rb;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic signed [7:0] a_s;
        logic signed [7:0] b_s;
        assign a_s              = ra_q[8*g +: 8];
        assign b_s              = rb_q[8*g +: 8];
        assign lane_d[8*g +: 8] = lane_op(f3_2_q, ra_q[8*g +: 8], rb_q[8*g +: 8]);
        assign prod_d[g]        = a_s * b_s;
    end

    // E2 -> E3
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_q   <= 1'b0;
            f3_3_q <= 3'b000;
            lane_q <= 32'h0;
            prod_q <= '0;
        end else if (!freeze) begin
            v3_q <= v2_q;
            if (v2_q) begin
                f3_3_q <= f3_2_q;
                lane_q <= lane_d;
                prod_q <= prod_d;
            end
        end
    end

    assign dot_e3 = {{16{prod_q[0][15]}}, prod_q[0]} + {{16{prod_q[1][15]}}, prod_q[1]}
                  + {{16{prod_q[2][15]}}, prod_q[2]} + {{16{prod_q[3][15]}}, prod_q[3]};

    // acc is read and written in E3 only, so back-to-back DOTACCs see each other's sums.
    always_comb begin
        out_d = lane_q;
        acc_d = acc_q;
        case (f3_3_q)
            F3_DOT8:   out_d = dot_e3;
            F3_DOTACC: begin
                out_d = acc_q + dot_e3;
                acc_d = acc_q + dot_e3;
            end
            F3_ACCCLR: begin
                out_d = 32'h0;
                acc_d = 32'h0;
            end
            default:   out_d = lane_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= 32'h0;
            acc_q       <= 32'h0;
        end else if (!freeze) begin
            out_valid_q <= v3_q;
            if (v3_q) begin
                out_q <= out_d;
                acc_q <= acc_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_exu_sprw_simd.sv
// Self-checking bench for exu_sprw_simd: directed vector table, hand sequences, and a randomized
// run checked against a lane-arithmetic reference model with an in-order result queue.
module tb_exu_sprw_simd;

    localparam logic [6:0] OPC_T = 7'b0001011;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        out_valid;
    logic [31:0] out;
    logic [31:0] acc;

    exu_sprw_simd #(.OPC(OPC_T)) dut (
        .clk       (clk),
        .rst       (rst),
        .freeze    (freeze),
        .in_valid  (in_valid),
        .instr     (instr),
        .ra        (ra),
        .rb        (rb),
        .out_valid (out_valid),
        .out       (out),
        .acc       (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int unsigned tgt;
        logic [31:0] o;
        logic [31:0] a;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[8];

    int unsigned ucnt    = 0;
    logic [31:0] m_acc   = 0;
    logic        vis_ov  = 0;
    logic [31:0] vis_out = 0;
    logic [31:0] vis_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain signed-integer lane arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] acc_in,
                                           output logic [31:0] acc_out);
        logic [31:0] r;
        logic [7:0]  bx;
        logic [7:0]  by;
        int x, y, s, dot;
        r = 0;
        dot = 0;
        acc_out = acc_in;
        for (int i = 0; i < 4; i++) begin
            bx = a[8*i +: 8];
            by = b[8*i +: 8];
            x = int'($signed(bx));
            y = int'($signed(by));
            case (f3)
                3'd1: s = x - y;
                3'd2: s = (x > y) ? x : y;
                3'd3: s = (x < y) ? x : y;
                3'd7: begin
                    s = x + y;
`ifdef RV_SPRW_SATADD_EN
                    if (s > 127)  s = 127;
                    if (s < -128) s = -128;
`endif
                end
                default: s = x + y;
            endcase
            r[8*i +: 8] = s[7:0];
            dot += x * y;
        end
        case (f3)
            3'd4: r = dot;
            3'd5: begin r = acc_in + dot; acc_out = r; end
            3'd6: begin r = 0; acc_out = 0; end
            default: ;
        endcase
        return r;
    endfunction

    task automatic set_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] w;
        w = $urandom;
        w[14:12] = f3;
        w[6:0] = OPC_T;
        in_valid = 1'b1;
        instr = w;
        ra = a;
        rb = b;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        instr = $urandom;
        ra = $urandom;
        rb = $urandom;
    endtask

    // One clock: model the accept, advance, then check outputs against the result queue.
    task automatic cycle();
        logic        acc_now;
        logic [31:0] eo;
        logic [31:0] ea;
        acc_now = in_valid && (instr[6:0] == OPC_T) && !freeze;
        eo = 0;
        ea = m_acc;
        if (acc_now) begin
            eo = ref_op(instr[14:12], ra, rb, m_acc, ea);
            m_acc = ea;
        end
        @(posedge clk);
        #1;
        if (!freeze) ucnt++;
        if (acc_now) q.push_back('{ucnt + 2, eo, ea});
        if (freeze) begin
            chk("hold_ov", {31'b0, out_valid}, {31'b0, vis_ov});
        end else if (q.size() > 0 && q[0].tgt == ucnt) begin
            vis_ov = 1'b1;
            vis_out = q[0].o;
            vis_acc = q[0].a;
            void'(q.pop_front());
            chk("res_ov", {31'b0, out_valid}, 32'd1);
        end else begin
            vis_ov = 1'b0;
            chk("bubble_ov", {31'b0, out_valid}, 32'd0);
        end
        chk("out", out, vis_out);
        chk("acc", acc, vis_acc);
    endtask

    task automatic model_reset();
        q.delete();
        m_acc = 0;
        vis_ov = 0;
        vis_out = 0;
        vis_acc = 0;
    endtask

    initial begin
        rst = 1'b1;
        freeze = 1'b0;
        idle();

        // ADD8 / SUB8 / MAX8 / MIN8 / DOT8 / SAT lane vectors; ACCCLR first so acc starts known.
        tbl[0] = '{3'b110, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000};
        tbl[1] = '{3'b000, 32'h7F01_FF10, 32'h0101_0110, 32'h8002_0020};
        tbl[2] = '{3'b001, 32'h0080_0110, 32'h0101_7F20, 32'hFF7F_82F0};
        // lanes: max(-128,127)=7F, max(-1,0)=00, max(0,-1)=00, max(1,0)=01
        tbl[3] = '{3'b010, 32'h80FF_0001, 32'h7F00_FF00, 32'h7F00_0001};
        tbl[4] = '{3'b011, 32'h80FF_0001, 32'h7F00_FF00, 32'h80FF_FF00};
        tbl[5] = '{3'b100, 32'h0102_0304, 32'h0101_0101, 32'h0000_000A};
        tbl[6] = '{3'b100, 32'h8080_8080, 32'h7F7F_7F7F, 32'hFFFF_0200};
`ifdef RV_SPRW_SATADD_EN
        tbl[7] = '{3'b111, 32'h7F80_0A00, 32'h01FF_0500, 32'h7F80_0F00};
`else
        tbl[7] = '{3'b111, 32'h7F80_0A00, 32'h01FF_0500, 32'h807F_0F00};
`endif

        // Reset hold: clocks and an issue strobe must not disturb the reset state.
        set_op(3'b101, 32'h0102_0304, 32'h0101_0101);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov", {31'b0, out_valid}, 32'd0);
        chk("rst_out", out, 32'd0);
        chk("rst_acc", acc, 32'd0);
        idle();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            set_op(tbl[i].f3, tbl[i].a, tbl[i].b);
            cycle();
            idle();
            cycle();
            cycle();
            chk("tbl_ov", {31'b0, out_valid}, 32'd1);
            chk("tbl_out", out, tbl[i].exp);
        end

        // DOT8 then two back-to-back DOTACCs.
        set_op(3'b110, 32'h0, 32'h0); cycle();
        set_op(3'b100, 32'h0102_0304, 32'h0101_0101); cycle();
        set_op(3'b101, 32'h0102_0304, 32'h0101_0101); cycle();
        set_op(3'b101, 32'h0102_0304, 32'h0101_0101); cycle();
        chk("chain_dot", out, 32'd10);
        idle(); cycle();
        chk("chain_acc1", out, 32'd10);
        chk("chain_acc1_a", acc, 32'd10);
        cycle();
        chk("chain_acc2", out, 32'd20);
        chk("chain_acc2_a", acc, 32'd20);

        // Opcode filter: wrong major opcode creates no valid and leaves acc alone.
        for (int i = 0; i < 3; i++) begin
            set_op(3'b101, 32'h0102_0304, 32'h0101_0101);
            instr[6:0] = 7'b0110011;
            cycle();
        end
        idle(); cycle(); cycle();
        chk("filt_ov", {31'b0, out_valid}, 32'd0);
        chk("filt_acc", acc, 32'd20);

        // Freeze for three edges mid-pipe; the issue strobe during freeze is ignored.
        set_op(3'b010, 32'h80FF_0001, 32'h7F00_FF00); cycle();
        idle(); cycle();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_op(3'b101, 32'h0102_0304, 32'h0101_0101);
            cycle();
            chk("frz_ov", {31'b0, out_valid}, 32'd0);
            chk("frz_acc", acc, 32'd20);
        end
        freeze = 1'b0;
        idle(); cycle();
        chk("frz_res_ov", {31'b0, out_valid}, 32'd1);
        chk("frz_res", out, 32'h7F00_0001);
        cycle();
        chk("frz_after_ov", {31'b0, out_valid}, 32'd0);

        // Async reset with a DOTACC in flight, asserted together with freeze.
        set_op(3'b101, 32'h0102_0304, 32'h0101_0101); cycle();
        idle();
        #2;
        freeze = 1'b1;
        rst = 1'b1;
        #1;
        chk("arst_ov", {31'b0, out_valid}, 32'd0);
        chk("arst_out", out, 32'd0);
        chk("arst_acc", acc, 32'd0);
        #1;
        rst = 1'b0;
        freeze = 1'b0;
        model_reset();
        cycle(); cycle(); cycle();
        set_op(3'b101, 32'h0102_0304, 32'h0101_0101); cycle();
        idle(); cycle(); cycle();
        chk("post_rst_acc", acc, 32'd10);
        chk("post_rst_out", out, 32'd10);

        // Randomized mix of ops, bubbles, freezes and foreign opcodes.
        for (int n = 0; n < 600; n++) begin
            freeze = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) != 0) begin
                set_op(3'($urandom_range(0, 7)), $urandom, $urandom);
                if ($urandom_range(0, 7) == 0) instr[6:0] = 7'($urandom);
                if ($urandom_range(0, 5) == 0) ra = {4{8'h80}};
                if ($urandom_range(0, 5) == 0) rb = {4{8'h7F}};
            end else begin
                idle();
            end
            cycle();
        end
        freeze = 1'b0;
        idle();
        repeat (3) cycle();
        chk("drain_q", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
